// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared MNIST image geometry and conv1 pixel streamer types
package mnist_pkg;

    localparam int IMG_W     = 28;
    localparam int IMG_H     = 28;
    localparam int PIX_CNT_W = $clog2(IMG_W * IMG_H);

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } streamer_state_t;

endpackage

// File: rtl/conv1_pixel_streamer_frame_bank.sv
// rtl/conv1_pixel_streamer_frame_bank.sv - WIDTH x HEIGHT bit image store, row write, bit read
module frame_bank #(
    parameter int WIDTH  = 28,
    parameter int HEIGHT = 28
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(HEIGHT)-1:0] waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [$clog2(HEIGHT)-1:0] raddr_row,
    input  logic [$clog2(WIDTH)-1:0]  raddr_col,
    output logic                      rdata
);

    // Image content deliberately survives reset.
    logic [WIDTH-1:0] mem_q [HEIGHT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr_row][raddr_col];

endmodule

// File: rtl/conv1_pixel_streamer.sv
// rtl/conv1_pixel_streamer.sv - row loader and raster pixel streamer; CONV1_STREAMER_PINGPONG_EN adds a second bank
module conv1_pixel_streamer
    import mnist_pkg::*;
#(
    parameter int WIDTH  = IMG_W,
    parameter int HEIGHT = IMG_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             row_valid,
    input  logic [WIDTH-1:0] row_data,
    output logic             row_ready,
    output logic             pixel_out,
    output logic             valid_out,
    output logic             sof_out,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    streamer_state_t state_q, state_d;
    logic [RW-1:0]   load_row_q, load_row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            pixel_q, pixel_d;
    logic            valid_q, valid_d;
    logic            sof_q, sof_d;
    logic            eof_q, eof_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic hs, last_hs, emit, rd_pixel, col_last, row_last;

    assign hs       = row_valid && row_ready;
    assign last_hs  = hs && (load_row_q == RW'(HEIGHT - 1));
    assign col_last = (col_q == CW'(WIDTH - 1));
    assign row_last = (row_q == RW'(HEIGHT - 1));

`ifdef CONV1_STREAMER_PINGPONG_EN
    // sel_q is the bank being streamed; the other bank takes rows.
    logic       sel_q, sel_d;
    logic       full_q, full_d;
    logic       b2b, rd_sel;
    logic [1:0] bank_bit;

    assign b2b       = (state_q == STREAM) && eof_q && (full_q || last_hs);
    assign rd_sel    = sel_q ^ b2b;
    assign row_ready = !full_q;
    assign rd_pixel  = bank_bit[rd_sel];

    frame_bank #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_bank0 (
        .clk       (clk),
        .we        (hs && sel_q),
        .waddr     (load_row_q),
        .wdata     (row_data),
        .raddr_row (row_q),
        .raddr_col (col_q),
        .rdata     (bank_bit[0])
    );

    frame_bank #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_bank1 (
        .clk       (clk),
        .we        (hs && !sel_q),
        .waddr     (load_row_q),
        .wdata     (row_data),
        .raddr_row (row_q),
        .raddr_col (col_q),
        .rdata     (bank_bit[1])
    );
`else
    assign row_ready = (state_q == LOAD);

    frame_bank #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_bank (
        .clk       (clk),
        .we        (hs),
        .waddr     (load_row_q),
        .wdata     (row_data),
        .raddr_row (row_q),
        .raddr_col (col_q),
        .rdata     (rd_pixel)
    );
`endif

    always_comb begin
        state_d    = state_q;
        load_row_d = load_row_q;
        col_d      = col_q;
        row_d      = row_q;
        pixel_d    = 1'b0;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        done_d     = 1'b0;
        emit       = 1'b0;
`ifdef CONV1_STREAMER_PINGPONG_EN
        sel_d      = sel_q;
        full_d     = full_q;
`endif

        if (hs) begin
            load_row_d = last_hs ? '0 : load_row_q + 1'b1;
        end

        unique case (state_q)
            LOAD: begin
                if (last_hs) begin
                    state_d = STREAM;
`ifdef CONV1_STREAMER_PINGPONG_EN
                    sel_d   = !sel_q;
`endif
                end
            end
            STREAM: begin
                // eof_q marks the cycle the last pixel is on the output.
                if (!eof_q) begin
                    emit = 1'b1;
`ifdef CONV1_STREAMER_PINGPONG_EN
                    if (last_hs) begin
                        full_d = 1'b1;
                    end
`endif
                end else begin
                    done_d = 1'b1;
`ifdef CONV1_STREAMER_PINGPONG_EN
                    if (b2b) begin
                        emit   = 1'b1;
                        sel_d  = !sel_q;
                        full_d = 1'b0;
                    end else begin
                        state_d = LOAD;
                    end
`else
                    state_d = LOAD;
`endif
                end
            end
            default: state_d = LOAD;
        endcase

        if (emit) begin
            valid_d = 1'b1;
            pixel_d = rd_pixel;
            sof_d   = (col_q == '0) && (row_q == '0);
            eof_d   = col_last && row_last;
            col_d   = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
        end
    end

    assign busy_d = valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            load_row_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pixel_q    <= 1'b0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef CONV1_STREAMER_PINGPONG_EN
            sel_q      <= 1'b0;
            full_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            load_row_q <= load_row_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pixel_q    <= pixel_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
`ifdef CONV1_STREAMER_PINGPONG_EN
            sel_q      <= sel_d;
            full_q     <= full_d;
`endif
        end
    end

    assign pixel_out  = pixel_q;
    assign valid_out  = valid_q;
    assign sof_out    = sof_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_conv1_pixel_streamer.sv
// tb/tb_conv1_pixel_streamer.sv - directed bench for conv1_pixel_streamer
module tb_conv1_pixel_streamer;
    import mnist_pkg::*;

    localparam int W    = IMG_W;
    localparam int H    = IMG_H;
    localparam int NPIX = W * H;
`ifdef CONV1_STREAMER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         row_valid;
    logic [W-1:0] row_data;
    logic         row_ready, pixel_out, valid_out, sof_out, frame_done, busy;

    int n_assert = 0;
    int n_fail   = 0;
    int ones;
    logic [W-1:0] img [2][H];

    conv1_pixel_streamer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .row_valid  (row_valid),
        .row_data   (row_data),
        .row_ready  (row_ready),
        .pixel_out  (pixel_out),
        .valid_out  (valid_out),
        .sof_out    (sof_out),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rows(input int b, input bit gaps, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            int t;
            if (gaps && r > 0) begin
                int g;
                g = int'($urandom_range(0, 3));
                row_valid = 1'b0;
                repeat (g) step();
            end
            row_valid = 1'b1;
            row_data  = img[b][r];
            t = 0;
            while (row_ready !== 1'b1 && t < 2000) begin
                step();
                t++;
            end
            chk("load_ready", row_ready, 1);
            step();
            chk("valid_during_load", valid_out, 0);
        end
        row_valid = 1'b0;
        row_data  = '0;
    endtask

    // Entered in the cycle that should show pixel (0,0).
    task automatic check_stream(input int b, input int nb, input bit load_next, input int abort_at,
                                input bit first_b2b, input bit next_b2b, output int n_ones);
        n_ones = 0;
        for (int p = 0; p < NPIX; p++) begin
            int r, c;
            r = p / W;
            c = p % W;
            if (p == abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("abort_valid", valid_out, 0);
                chk("abort_done", frame_done, 0);
                chk("abort_busy", busy, 0);
                repeat (3) begin
                    step();
                    chk("abort_done_later", frame_done, 0);
                    chk("abort_ready", row_ready, 1);
                end
                return;
            end
            if (load_next) begin
                row_valid = (p < H);
                row_data  = (p < H) ? img[nb][p] : '0;
            end
            chk("stream_valid", valid_out, 1);
            chk("stream_pixel", pixel_out, img[b][r][c]);
            chk("stream_sof", sof_out, (p == 0));
            chk("stream_busy", busy, 1);
            chk("stream_ready", row_ready, PP ? (load_next ? (p < H) : 1) : 0);
            if (p == 0) chk("first_done", frame_done, first_b2b);
            n_ones += int'(pixel_out);
            step();
        end
        if (load_next) row_valid = 1'b0;
        chk("end_done", frame_done, 1);
        chk("end_valid", valid_out, next_b2b);
        chk("end_sof", sof_out, next_b2b);
        chk("end_busy", busy, next_b2b);
        if (!next_b2b) chk("end_ready", row_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        row_valid = 1'b0;
        row_data  = '0;
        step();
        step();
        chk("rst_valid", valid_out, 0);
        chk("rst_sof", sof_out, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pixel", pixel_out, 0);
        rst = 1'b0;
        step();
        chk("idle_ready", row_ready, 1);
        chk("idle_valid", valid_out, 0);

        // Diagonal frame; single-bank build also holds zero rows valid during streaming.
        for (int r = 0; r < H; r++) img[0][r] = W'(1) << r;
        load_rows(0, 1'b0, H);
        row_valid = !PP;
        row_data  = '0;
        step();
        check_stream(0, 0, 1'b0, -1, 1'b0, 1'b0, ones);
        chk("diag_ones", ones, H);

        // Next load handshakes in the frame_done cycle; gapped all-ones frame.
        for (int r = 0; r < H; r++) img[1][r] = '1;
        load_rows(1, 1'b1, H);
        step();
        check_stream(1, 0, 1'b0, -1, 1'b0, 1'b0, ones);
        chk("ones_count", ones, NPIX);

        // Reset at pixel 400, then partial load, reset, and a fresh full load.
        for (int r = 0; r < H; r++) img[0][r] = W'(32'h0F0F_0F0F >> (r % 4)) ^ W'(r);
        for (int r = 0; r < H; r++) img[1][r] = ~img[0][r];
        load_rows(0, 1'b0, H);
        step();
        check_stream(0, 0, 1'b0, 400, 1'b0, 1'b0, ones);
        load_rows(0, 1'b0, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("partial_rst_valid", valid_out, 0);
        load_rows(1, 1'b1, H);
        step();
        chk("new_frame_px00", pixel_out, 0);
        check_stream(1, 0, 1'b0, -1, 1'b0, 1'b0, ones);

`ifdef CONV1_STREAMER_PINGPONG_EN
        // Frame B preloaded while frame A streams; the two run back to back.
        for (int r = 0; r < H; r++) img[0][r] = W'(1) << r;
        for (int r = 0; r < H; r++) img[1][r] = W'(32'h0FFF_FFFF >> r);
        load_rows(0, 1'b0, H);
        step();
        check_stream(0, 1, 1'b1, -1, 1'b0, 1'b1, ones);
        chk("pp_a_ones", ones, H);
        check_stream(1, 0, 1'b0, -1, 1'b1, 1'b0, ones);
        chk("pp_b_ones", ones, H * (H + 1) / 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/conv1_pixel_streamer.md
Name: conv1_pixel_streamer

Overview:
- Transmit end of the conv layer 1 pixel interface: produces the 1-bit `pixel_out`/`valid_out` raster stream that drives the first-layer line buffer.
- Accepts a binarized image one row at a time over a ready/valid load port and stores it in an internal WIDTH x HEIGHT bit array.
- Once the image is complete, streams it one pixel per clock, row-major, with no gaps. The downstream side has no backpressure.

Parameters:
- WIDTH, 28, image columns; also the `row_data` width.
- HEIGHT, 28, image rows per frame.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- row_valid  in  1  load port: `row_data` is valid.
- row_data  in  WIDTH  one image row; bit 0 = column 0 (leftmost).
- row_ready  out  1  load port: a row is accepted when `row_valid && row_ready` at the clock edge.
- pixel_out  out  1  streamed pixel; meaningful only when `valid_out` = 1.
- valid_out  out  1  `pixel_out` is valid. This is the `valid_in` of the consumer.
- sof_out  out  1  high with the frame's pixel (0,0).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.
- busy  out  1  high while in STREAM.

Interface decision: one clock, `clk`; reset is `rst`, synchronous and active-high.

Behaviour:
- Reset
  - On an edge with `rst` = 1, state returns to LOAD and row/pixel counters clear.
  - Registered outputs `pixel_out`, `valid_out`, `sof_out`, `frame_done` and `busy` are 0 in the following cycle.
  - Stored image content is not cleared. A partial load is discarded.
  - Reset mid-stream aborts the frame. No `frame_done` is issued for it.
- State machine: LOAD, STREAM.
  - LOAD:
    - `row_ready` = 1, combinational on state.
    - Each handshake writes `row_data` into row `row_cnt` and increments `row_cnt`.
    - The handshake on row HEIGHT-1 moves the state to STREAM at that edge.
    - Rows with `row_valid` = 0 are not written. Gaps between rows are allowed.
  - STREAM:
    - `row_ready` = 0. `row_valid` is ignored and stored data is never modified.
    - `pix_cnt` runs 0 .. WIDTH*HEIGHT-1, with col = `pix_cnt` mod WIDTH and row = `pix_cnt` / WIDTH.
    - Implement col/row as two wrap counters; no divider.
- Output timing
  - Final-row handshake at edge k gives `valid_out` = 1 with pixel (0,0) and `sof_out` = 1 after edge k+1.
  - The last pixel (HEIGHT-1, WIDTH-1) is present after edge k+WIDTH*HEIGHT.
  - After edge k+WIDTH*HEIGHT+1: `valid_out` = 0, `frame_done` = 1 for exactly one cycle, state = LOAD, `row_ready` = 1.
  - `valid_out` is continuous for exactly WIDTH*HEIGHT cycles (784 by default), with no bubbles.
- `busy` = 1 exactly in the cycles where `valid_out` = 1 for the current frame.
- Counter widths are `$clog2(WIDTH)` and `$clog2(HEIGHT)`; wrap compare is against WIDTH-1 and HEIGHT-1, not power-of-two overflow.
- No arithmetic beyond counter increments; the pixel is a direct bit select.

Optional Feature:
- Macro `CONV1_STREAMER_PINGPONG_EN`.
- Defined:
  - Two banks. While one bank streams, the other accepts rows, so `row_ready` = 1 whenever the load bank holds fewer than HEIGHT rows.
  - If the load bank is full when the last pixel is emitted, the next frame starts on the following edge.
  - In that back-to-back case, `valid_out` stays high and `sof_out` = 1 coincides with `frame_done` = 1.
  - If the load bank is not full, behaviour matches the single-bank case: `valid_out` drops and streaming starts one edge after that bank's final row handshake.
  - A full load bank holds `row_ready` = 0 until it becomes the stream bank.
  - Reset clears both fill states.
- Undefined: single bank, exactly as specified above.

Decomposition:
- Shared package `mnist_pkg`:
  - IMG_W = 28 and IMG_H = 28 (shared with the conv1 line buffer).
  - The `streamer_state_t` enum {LOAD, STREAM}.
  - The PIX_CNT_W localparam.
- Sub-module `frame_bank`:
  - WIDTH x HEIGHT bit array with a row write port (we, waddr, wdata) and a combinational bit read (raddr_row, raddr_col).
  - Instantiated once, or twice under `CONV1_STREAMER_PINGPONG_EN`.

Test Plan:
- Load 28 rows where row r = 28'h1 << r (diagonal), `row_valid` held high:
  - exactly 784 `valid_out` cycles;
  - `pixel_out` = 1 only at `pix_cnt` = 29*r;
  - `sof_out` on cycle 1 only;
  - `frame_done` one cycle after the last pixel.
- Random gaps on `row_valid`, all rows 28'hFFFFFFF → 784 ones with no bubbles; the first pixel arrives exactly one edge after the 28th handshake.
- Drive `row_valid` = 1 with row_data 28'h0 throughout STREAM → `row_ready` = 0, streamed image unchanged; the next load is accepted in the `frame_done` cycle.
- Assert `rst` at pixel 400 → the next cycle shows `valid_out` = 0 and `frame_done` stays 0. A fresh 28-row load then streams its own content; pixel (0,0) comes from the new frame.
- Reset after 10 rows loaded, then load 28 new rows → streaming starts only after 28 new handshakes.
- With `CONV1_STREAMER_PINGPONG_EN`, preload frame B during frame A:
  - `valid_out` high for 1568 consecutive cycles;
  - `frame_done` and `sof_out` both 1 on cycle 785;
  - frame B content correct.
